tdc_loop_filter: RTL
====================

TDC_LOOP_FILTER -- requirements
Module: tdc_loop_filter

Interface
REQ-001 Parameter: KP_ACQ_SH, 2, proportional right-shift in ACQ state.
REQ-002 Parameter: KP_TRK_SH, 5, proportional right-shift in TRACK state.
REQ-003 Parameter: KI_SH, 8, integral right-shift.
REQ-004 Parameter: DCO_MID, 32768, dco_ctrl value at reset and during SETTLE.
REQ-005 Parameter: LOCK_THR, 2, maximum |err| counted as in-lock.
REQ-006 Parameter: UNLOCK_THR, 16, |err| above this drops lock.
REQ-007 Parameter: LOCK_CNT, 8, consecutive in-lock samples required to lock.
REQ-008 Parameter: SETTLE_N, 2, en samples discarded after reset.
REQ-009 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-010 Port: rst  in  1  synchronous, active-high reset.
REQ-011 Port: en  in  1  sample strobe; tdc_word is consumed on each rising edge with en=1.
REQ-012 Port: fcw  in  12  frequency command word, expected tdc_word per reference cycle, unsigned.
REQ-013 Port: tdc_word  in  12  modulo-4096 measured DCO phase increment from TDC.
REQ-014 Port: dco_ctrl  out  16  registered unsigned DCO tuning word.
REQ-015 Port: dco_valid  out  1  one-cycle pulse on each edge that updates dco_ctrl.
REQ-016 Port: locked  out  1  high while in TRACK state.
REQ-017 Port: err_out  out  12  registered signed frequency error of last consumed sample.

Function
REQ-018 err SHALL be (fcw - tdc_word) mod 4096, interpreted as 12-bit two's complement, range -2048..2047.
REQ-019 States SHALL be SETTLE, ACQ, TRACK; en=0 edges SHALL hold all state, counters, and outputs, and drive dco_valid=0.
REQ-020 SETTLE SHALL count en samples without updating accumulators or dco_ctrl; after the SETTLE_N-th sample it SHALL enter ACQ.
REQ-021 On each en edge in ACQ/TRACK: phe_n = sat16(phe + err), integ_n = sat24(integ + phe_n), with signed saturation to [-2^15, 2^15-1] and [-2^23, 2^23-1].
REQ-022 The same edge SHALL register dco_ctrl = clamp(DCO_MID + (phe_n >>> KP_SH) + (integ_n >>> KI_SH), 0, 65535).
REQ-023 KP_SH SHALL be KP_ACQ_SH in ACQ and KP_TRK_SH in TRACK, selected by the state before the edge; >>> is arithmetic, floors toward negative infinity.
REQ-024 Latency: dco_ctrl, err_out, dco_valid SHALL reflect a sample one cycle after the consuming edge.
REQ-025 In ACQ, lock counter SHALL increment when |err| <= LOCK_THR and clear otherwise; reaching LOCK_CNT SHALL move to TRACK and set locked on that same edge.
REQ-026 In TRACK, a single sample with |err| > UNLOCK_THR SHALL move to ACQ, clear locked and lock counter on that edge; accumulators are not cleared.
REQ-027 |err| for -2048 SHALL be 2048 (13-bit magnitude, no overflow).

Reset
REQ-028 rst=1 on an edge SHALL force SETTLE, settle and lock counters 0, phe=0, integ=0, dco_ctrl=DCO_MID, dco_valid=0, locked=0, err_out=0.
REQ-029 rst SHALL take priority over en on the same edge; reset mid-ACQ/TRACK SHALL discard all loop state.

Verification
REQ-030 fcw=100, tdc_word=100, en=1 constant -> no dco_valid for 2 samples, dco_ctrl=32768 throughout, locked rises on the 10th en edge.
REQ-031 Defaults, fcw=100, tdc_word=99 after settle, KP_ACQ_SH=0, KI_SH=4 override -> dco_ctrl 32769, then 32770 (phe 1,2; integ 1,3).
REQ-032 fcw=5, tdc_word=4090 -> err_out=+11; fcw=4090, tdc_word=5 -> err_out=-11 (0xFF5).
REQ-033 err=+2047 constant after settle -> phe 32752 after 16 samples, saturates at 32767 on the 17th; dco_ctrl clamps at 65535, never wraps.
REQ-034 In TRACK, one sample err=+17 -> locked falls that edge, state ACQ; en=0 gap mid-run -> outputs frozen, dco_valid=0.
REQ-035 rst asserted with en=1 while locked -> next cycle dco_ctrl=32768, locked=0, and 2 samples discarded before the next dco_valid.

Source files
------------

// File: rtl/tdc_loop_filter.sv
// Type-II PI loop filter for a TDC-based ADPLL: phase-error accumulation, integral path,
// settle/acquire/track lock supervision and a clamped, registered DCO tuning word.
module tdc_loop_filter #(
    parameter int unsigned KP_ACQ_SH  = 2,
    parameter int unsigned KP_TRK_SH  = 5,
    parameter int unsigned KI_SH      = 8,
    parameter int unsigned DCO_MID    = 32768,
    parameter int unsigned LOCK_THR   = 2,
    parameter int unsigned UNLOCK_THR = 16,
    parameter int unsigned LOCK_CNT   = 8,
    parameter int unsigned SETTLE_N   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [11:0] fcw,
    input  logic [11:0] tdc_word,
    output logic [15:0] dco_ctrl,
    output logic        dco_valid,
    output logic        locked,
    output logic [11:0] err_out
);
    localparam int unsigned SCW = (SETTLE_N > 0) ? $clog2(SETTLE_N + 1) : 1;
    localparam int unsigned LCW = (LOCK_CNT > 0) ? $clog2(LOCK_CNT + 1) : 1;
    localparam logic [31:0] MID = 32'(DCO_MID);

    typedef enum logic [1:0] {SETTLE, ACQ, TRACK} state_t;

    state_t             state_q;
    logic [SCW-1:0]     settle_q;
    logic [LCW-1:0]     lock_cnt_q;
    logic signed [15:0] phe_q, phe_d;
    logic signed [23:0] integ_q, integ_d;
    logic [15:0]        dco_q, dco_d;
    logic               valid_q;
    logic               locked_q;
    logic [11:0]        err_q;

    logic [11:0]        err;
    logic [12:0]        abs_err;
    logic [16:0]        phe_sum;
    logic [24:0]        integ_sum;
    logic signed [15:0] phe_sh;
    logic signed [23:0] integ_sh;
    logic [31:0]        dco_sum;
    logic               in_lock;
    logic               out_lock;

    always_comb begin
        err     = fcw - tdc_word;
        // 13-bit magnitude so that -2048 maps to 2048 without overflow
        abs_err = err[11] ? (13'd0 - {1'b1, err}) : {1'b0, err};

        phe_sum = {phe_q[15], phe_q} + {{5{err[11]}}, err};
        if (phe_sum[16] != phe_sum[15]) begin
            phe_d = phe_sum[16] ? 16'sh8000 : 16'sh7FFF;
        end else begin
            phe_d = phe_sum[15:0];
        end

        integ_sum = {integ_q[23], integ_q} + {{9{phe_d[15]}}, phe_d};
        if (integ_sum[24] != integ_sum[23]) begin
            integ_d = integ_sum[24] ? 24'sh800000 : 24'sh7FFFFF;
        end else begin
            integ_d = integ_sum[23:0];
        end

        phe_sh   = (state_q == TRACK) ? (phe_d >>> KP_TRK_SH) : (phe_d >>> KP_ACQ_SH);
        integ_sh = integ_d >>> KI_SH;

        // Sum in 32 bits so negative results and values above 16 bits are both visible for clamping
        dco_sum = MID + {{16{phe_sh[15]}}, phe_sh} + {{8{integ_sh[23]}}, integ_sh};
        if (dco_sum[31]) begin
            dco_d = '0;
        end else if (|dco_sum[30:16]) begin
            dco_d = '1;
        end else begin
            dco_d = dco_sum[15:0];
        end

        in_lock  = 32'(abs_err) <= LOCK_THR;
        out_lock = 32'(abs_err) > UNLOCK_THR;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SETTLE;
            settle_q   <= '0;
            lock_cnt_q <= '0;
            phe_q      <= '0;
            integ_q    <= '0;
            dco_q      <= 16'(DCO_MID);
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
            err_q      <= '0;
        end else if (en) begin
            err_q <= err;
            case (state_q)
                SETTLE: begin
                    valid_q <= 1'b0;
                    if (32'(settle_q) + 1 >= SETTLE_N) begin
                        state_q  <= ACQ;
                        settle_q <= '0;
                    end else begin
                        settle_q <= settle_q + SCW'(1);
                    end
                end
                default: begin
                    phe_q   <= phe_d;
                    integ_q <= integ_d;
                    dco_q   <= dco_d;
                    valid_q <= 1'b1;
                    if (state_q == ACQ) begin
                        if (!in_lock) begin
                            lock_cnt_q <= '0;
                        end else if (32'(lock_cnt_q) + 1 >= LOCK_CNT) begin
                            state_q    <= TRACK;
                            locked_q   <= 1'b1;
                            lock_cnt_q <= '0;
                        end else begin
                            lock_cnt_q <= lock_cnt_q + LCW'(1);
                        end
                    end else if (out_lock) begin
                        state_q    <= ACQ;
                        locked_q   <= 1'b0;
                        lock_cnt_q <= '0;
                    end
                end
            endcase
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign dco_ctrl  = dco_q;
    assign dco_valid = valid_q;
    assign locked    = locked_q;
    assign err_out   = err_q;

endmodule
